// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT input sequencer: default sizes, FSM states
// and a compile-time log2 helper.
package ntt_pkg;

    localparam int NTT_N      = 16;
    localparam int NTT_WIDTH  = 32;
    localparam int NTT_Q      = 7681;
    localparam int NTT_DRAIN  = 1;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    function automatic int ntt_log2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((32'sd1 <<< k) < v) begin
                r = k + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_coef_buffer.sv
// N-entry coefficient store: written in arrival order with mod-Q reduction,
// read combinationally at an arbitrary index.
module ntt_coef_buffer
    import ntt_pkg::*;
#(
    parameter int N     = NTT_N,
    parameter int WIDTH = NTT_WIDTH,
    parameter int Q     = NTT_Q,
    parameter int AW    = ntt_log2(NTT_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [N];

    // Capture reduced coefficients; reset clears any partial run.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                mem_q[k] <= {WIDTH{1'b0}};
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data % WIDTH'(Q);
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/ntt_input_sequencer.sv
// Front end of the 16-PE NTT array: buffers N coefficients, programs each PE
// with its output index, then streams (j, a_j) pairs and flags completion.
module ntt_input_sequencer
    import ntt_pkg::*;
#(
    parameter int N            = NTT_N,
    parameter int WIDTH        = NTT_WIDTH,
    parameter int Q            = NTT_Q,
    parameter int DRAIN_CYCLES = NTT_DRAIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             array_rst,
    output logic [WIDTH-1:0] reg_en_index,
    output logic [WIDTH-1:0] reg_value,
    output logic [WIDTH-1:0] lane0,
    output logic [WIDTH-1:0] lane1,
    output logic             busy,
    output logic             done
);

    localparam int AW = ntt_log2(N);
    localparam int CW = AW + 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept_s;
    logic [WIDTH-1:0] rd_data_s;

    logic             in_ready_q, in_ready_d;
    logic             array_rst_q, array_rst_d;
    logic [WIDTH-1:0] reg_en_q, reg_en_d;
    logic [WIDTH-1:0] reg_val_q, reg_val_d;
    logic [WIDTH-1:0] lane0_q, lane0_d;
    logic [WIDTH-1:0] lane1_q, lane1_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    assign accept_s = in_valid && in_ready_q && (state_q == FILL);

    ntt_coef_buffer #(.N(N), .WIDTH(WIDTH), .Q(Q), .AW(AW)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept_s),
        .wr_addr (cnt_q[AW-1:0]),
        .wr_data (in_data),
        .rd_addr (cnt_q[AW-1:0]),
        .rd_data (rd_data_s)
    );

    // State and phase counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: one shared counter walks each phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            FILL: begin
                if (accept_s && (cnt_q == CW'(N - 1))) begin
                    state_d = LOAD;
                    cnt_d   = {CW{1'b0}};
                end else if (accept_s) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            LOAD: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = STREAM;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STREAM: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                // The extra count past DRAIN_CYCLES is the cycle that raises done.
                if (cnt_q == CW'(DRAIN_CYCLES)) begin
                    state_d = FILL;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Output decode, registered one edge behind the state it reflects.
    always_comb begin
        in_ready_d  = (state_d == FILL);
        array_rst_d = 1'b0;
        reg_en_d    = {WIDTH{1'b0}};
        reg_val_d   = {WIDTH{1'b0}};
        lane0_d     = {WIDTH{1'b0}};
        lane1_d     = {WIDTH{1'b0}};
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            LOAD: begin
                array_rst_d = 1'b1;
                reg_en_d    = WIDTH'(cnt_q) + WIDTH'(1);
                reg_val_d   = WIDTH'(cnt_q);
                busy_d      = 1'b1;
            end
            STREAM: begin
                lane0_d = WIDTH'(cnt_q);
                lane1_d = rd_data_s;
                busy_d  = 1'b1;
            end
            DRAIN: begin
                if (cnt_q == CW'(DRAIN_CYCLES)) begin
                    done_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            array_rst_q <= 1'b0;
            reg_en_q    <= {WIDTH{1'b0}};
            reg_val_q   <= {WIDTH{1'b0}};
            lane0_q     <= {WIDTH{1'b0}};
            lane1_q     <= {WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            array_rst_q <= array_rst_d;
            reg_en_q    <= reg_en_d;
            reg_val_q   <= reg_val_d;
            lane0_q     <= lane0_d;
            lane1_q     <= lane1_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign array_rst    = array_rst_q;
    assign reg_en_index = reg_en_q;
    assign reg_value    = reg_val_q;
    assign lane0        = lane0_q;
    assign lane1        = lane1_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: doc/ntt_input_sequencer.md
Name: ntt_input_sequencer

Overview:
- Upstream stage of the 16-PE NTT systolic array.
- Buffers N input coefficients through a valid/ready stream.
- Drives the array's internal-register load bus to program each PE with its output index k.
- Then streams (index j, coefficient a_j) pairs onto lanes 0/1, holding the array in reset during programming and releasing it for accumulation. Signals done when every PEValue holds its final NTT output.

Parameters:
- N, 16, transform length = PE count; power of two.
- WIDTH, 32, data/lane width.
- Q, 7681, modulus; input coefficients are reduced mod Q on capture.
- DRAIN_CYCLES, 1, cycles after the last streamed pair before done (PE accumulate latency).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  coefficient beat valid
- in_ready  out  1  sequencer can accept a beat
- in_data  in  WIDTH  coefficient a_j, arriving in order j=0..N-1
- array_rst  out  1  drives the systolic array rst
- reg_en_index  out  WIDTH  drives InternalRegisterEnableIndex; 0 selects no PE
- reg_value  out  WIDTH  drives InternalRegisterInputValue0
- lane0  out  WIDTH  drives Dim0InputLane0 (index j)
- lane1  out  WIDTH  drives Dim0InputLane1 (coefficient)
- busy  out  1  high in LOAD, STREAM and DRAIN
- done  out  1  one-cycle pulse; array PEValues are final

Behaviour:
- All outputs are registered. Reset values:
  - in_ready=1
  - array_rst=0, reg_en_index=0, reg_value=0, lane0=0, lane1=0
  - busy=0, done=0
  - state=FILL, fill count=0
- FILL state:
  - in_ready=1 while count<N.
  - On each in_valid&&in_ready edge: buf[count] <= in_data % Q; count++.
  - The edge accepting beat N-1 (edge E) enters LOAD; in_ready is 0 from the next cycle.
  - Lanes and reg_en_index stay 0 and array_rst stays 0, so existing PEValues hold (lane1=0 adds nothing).
- LOAD state, N cycles, counter i=0..N-1:
  - array_rst=1, reg_en_index=i+1, reg_value=i.
  - Values for i are visible after edge E+1+i.
  - array_rst high clears the PE accumulators and loads their twiddle tables.
- STREAM state, N cycles, j=0..N-1:
  - array_rst=0, reg_en_index=0, lane0=j, lane1=buf[j].
  - Visible after edge E+1+N+j.
- DRAIN state, DRAIN_CYCLES cycles: lanes=0, array_rst=0.
- done:
  - High for exactly one cycle after edge E+1+2N+DRAIN_CYCLES (E+34 at defaults).
  - The state returns to FILL on that same edge, with count=0 and in_ready=1.
- busy is high exactly for the cycles in which LOAD, STREAM or DRAIN outputs are visible.
- in_valid outside FILL, or while in_ready=0, is ignored; no beat is captured.
- rst mid-operation:
  - Immediately returns all outputs to their reset values and the state to FILL.
  - Discards the partial buffer; no done pulse.
- in_data >= Q is reduced modulo Q. Counters are sized to clog2(N)+1 bits. Lane values are zero-extended to WIDTH.

Decomposition:
- Shared package ntt_pkg:
  - N, Q, WIDTH defaults
  - state enum {FILL, LOAD, STREAM, DRAIN}
  - log2 helper
- One natural sub-module, ntt_coef_buffer: N-entry write-sequential / read-indexed register file with mod-Q reduction on write.
- The FSM and counters stay in the top.

Test Plan:
- Reset, then send 16 beats in_data=1..16 with in_valid held high.
  - in_ready drops after the 16th handshake.
  - array_rst=1 for exactly 16 cycles, with reg_en_index 1..16 paired with reg_value 0..15.
  - Lanes then show (0,1)…(15,16).
  - done pulses exactly 34 cycles after the 16th handshake.
- Integrated with the systolic array and the same stimulus:
  - After done, PE0 PEValue=136.
  - Every PE k equals sum_j a_j·w^(jk) mod 7681, checked against a reference model.
- Throttled input: in_valid toggles 1/0 every cycle.
  - Buffer captures only the handshake beats; lanes still stream 1..16 in order.
  - Total latency from the last handshake is unchanged at 34.
- Input reduction: in_data=7681 for beat 0 and 7682 for beat 1 -> lane1 streams 0 then 1.
- Reset asserted on the 5th STREAM cycle:
  - Next cycle all outputs are 0, in_ready=1, no done pulse.
  - A following full 16-beat run completes normally with correct results.
- Back-to-back runs: second run's beats accepted immediately after done; the second done arrives 34 cycles after its last handshake.
